// File: rtl/link_delay_emulator_pkg.sv
// Shared width helpers, packed-bus slice macro and parameter legality checks
// for the link delay emulator.
`ifndef LDE_SLICE
`define LDE_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package link_delay_emulator_pkg;

  localparam int unsigned MaxDelay = 1023;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned delay);
    return $clog2(delay + 1);
  endfunction

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit delay_legal(input int unsigned delay);
    return (delay >= 1) && (delay <= MaxDelay);
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/link_delay_emulator_channel.sv
// One delayed valid/ready stream: a FIFO whose entries each carry a countdown
// that must reach zero before the entry may leave.
module link_delay_channel
  import link_delay_emulator_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Delay     = 53,
  parameter int unsigned Depth     = 64,
  localparam int unsigned PtrW     = ptr_w(Depth),
  localparam int unsigned CntW     = cnt_w(Delay),
  localparam int unsigned OccW     = occ_w(Depth)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 link_enable_i,
  output logic [OccW-1:0]      occupancy_o
);

  if (!delay_legal(Delay)) begin : g_bad_delay
    $error("link_delay_channel: Delay must be in 1..1023");
  end
  if (!depth_legal(Depth)) begin : g_bad_depth
    $error("link_delay_channel: Depth must be a power of two >= 2");
  end

  logic [DataWidth-1:0]            mem_q [Depth];
  logic [Depth-1:0][CntW-1:0]      cnt_q, cnt_d, cnt_dec;
  logic [PtrW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]                 occ_q, occ_d;
  logic [DataWidth-1:0]            out_data_q, out_data_d;
  logic                            push, pop, head_ready, empty_after_pop;

  // Every slot ages, occupied or not; free slots simply sit at zero.
  for (genvar g = 0; g < Depth; g++) begin : g_age
    assign cnt_dec[g] = (cnt_q[g] == '0) ? '0 : cnt_q[g] - 1'b1;
  end

  assign head_ready  = (occ_q != '0) && (cnt_q[rd_ptr_q] == '0);
  assign in_ready_o  = link_enable_i & ~reset_i & (occ_q < OccW'(Depth));
  assign out_valid_o = link_enable_i & head_ready;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  assign out_data_o  = out_data_q;
  assign occupancy_o = occ_q;

  always_comb begin
    wr_ptr_d        = wr_ptr_q + PtrW'(push);
    rd_ptr_d        = rd_ptr_q + PtrW'(pop);
    occ_d           = occ_q + OccW'(push) - OccW'(pop);
    cnt_d           = cnt_dec;
    empty_after_pop = (occ_q == OccW'(pop));
    if (push) begin
      cnt_d[wr_ptr_q] = CntW'(Delay);
    end
    // Keep out_data_q equal to whatever entry will be at the head next cycle.
    if (!empty_after_pop) begin
      out_data_d = mem_q[rd_ptr_d];
    end else if (push) begin
      out_data_d = in_data_i;
    end else begin
      out_data_d = out_data_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/link_delay_emulator.sv
// Fixed-latency inter-FPGA link model: NumChannels independent delayed streams
// packed onto flat buses.
module link_delay_emulator
  import link_delay_emulator_pkg::*;
#(
  parameter int unsigned NumChannels = 8,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned Delay       = 53,
  parameter int unsigned Depth       = 64,
  localparam int unsigned OccW       = occ_w(Depth)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NumChannels*DataWidth-1:0] in_data_i,
  input  logic [NumChannels-1:0]           in_valid_i,
  output logic [NumChannels-1:0]           in_ready_o,
  output logic [NumChannels*DataWidth-1:0] out_data_o,
  output logic [NumChannels-1:0]           out_valid_o,
  input  logic [NumChannels-1:0]           out_ready_i,
  input  logic [NumChannels-1:0]           link_enable_i,
  output logic [NumChannels*OccW-1:0]      occupancy_o
);

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    link_delay_channel #(
      .DataWidth (DataWidth),
      .Delay     (Delay),
      .Depth     (Depth)
    ) u_chan (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .in_data_i     (`LDE_SLICE(in_data_i, c, DataWidth)),
      .in_valid_i    (in_valid_i[c]),
      .in_ready_o    (in_ready_o[c]),
      .out_data_o    (`LDE_SLICE(out_data_o, c, DataWidth)),
      .out_valid_o   (out_valid_o[c]),
      .out_ready_i   (out_ready_i[c]),
      .link_enable_i (link_enable_i[c]),
      .occupancy_o   (`LDE_SLICE(occupancy_o, c, OccW))
    );
  end

endmodule

// File: tb/tb_link_delay_emulator.sv
// Bench for link_delay_emulator: queue-of-timestamps model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_link_delay_emulator;

  localparam int NCH = 8;
  localparam int DW  = 64;
  localparam int DLY = 53;
  localparam int DEP = 64;
  localparam int OW  = $clog2(DEP) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH*DW-1:0]   in_data = '0;
  logic [NCH-1:0]      in_valid = '0;
  logic [NCH-1:0]      in_ready;
  logic [NCH*DW-1:0]   out_data;
  logic [NCH-1:0]      out_valid;
  logic [NCH-1:0]      out_ready = '1;
  logic [NCH-1:0]      link_enable = '1;
  logic [NCH*OW-1:0]   occupancy;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  link_delay_emulator #(
    .NumChannels (NCH),
    .DataWidth   (DW),
    .Delay       (DLY),
    .Depth       (DEP)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .link_enable_i (link_enable),
    .occupancy_o   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int occ(input int c);
    return int'(occupancy[c*OW +: OW]);
  endfunction

  // Model: each channel is a queue of (payload, edge number of its push).
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  ent_t mq [NCH][$];
  int   edge_n = 0;
  bit   push_m [NCH];
  bit   pop_m  [NCH];
  ent_t e_new;

  function automatic bit exp_valid(input int c);
    if (!link_enable[c] || mq[c].size() == 0) return 1'b0;
    return (edge_n - mq[c][0].t) >= DLY;
  endfunction

  function automatic bit exp_ready(input int c);
    return link_enable[c] && (mq[c].size() < DEP);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        pop_m[c]  = out_ready[c] && exp_valid(c);
        push_m[c] = in_valid[c] && exp_ready(c);
      end
      edge_n++;
      for (int c = 0; c < NCH; c++) begin
        if (pop_m[c]) void'(mq[c].pop_front());
        if (push_m[c]) begin
          e_new.d = in_data[c*DW +: DW];
          e_new.t = edge_n;
          mq[c].push_back(e_new);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("model in_ready[%0d] t=%0d", c, edge_n), in_ready[c], exp_ready(c));
        chk($sformatf("model out_valid[%0d] t=%0d", c, edge_n), out_valid[c], exp_valid(c));
        chk($sformatf("model occupancy[%0d] t=%0d", c, edge_n), occ(c), mq[c].size());
        if (exp_valid(c))
          chk($sformatf("model out_data[%0d] t=%0d", c, edge_n), out_data[c*DW +: DW],
              mq[c][0].d);
      end
    end
  end

  int run;
  int seen;
  int pops3 = 0;
  always @(negedge clk) if (!rst && out_valid[3] && out_ready[3]) pops3++;

  initial begin
    repeat (3) tick();
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset occupancy", 64'(occupancy), 64'd0);
    chk("reset out_data", 64'(|out_data), 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (5) tick();

    // Single word on ch0.
    in_data[0 +: DW] = 64'hDEAD_BEEF_0000_0001;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    chk("single occ after push", occ(0), 1);
    repeat (DLY - 1) tick();
    chk("single not valid at DELAY-1", out_valid[0], 0);
    tick();
    chk("single valid at DELAY", out_valid[0], 1);
    chk("single data", out_data[0 +: DW], 64'hDEAD_BEEF_0000_0001);
    tick();
    chk("single occ after pop", occ(0), 0);

    // Streaming 200 words on ch3.
    pops3 = 0;
    for (int i = 0; i < 200; i++) begin
      in_data[3*DW +: DW] = 64'h3000 + 64'(i);
      in_valid[3] = 1'b1;
      tick();
      if (i == DLY - 1) chk("stream not valid at DELAY-1", out_valid[3], 0);
      if (i == DLY) begin
        chk("stream first valid", out_valid[3], 1);
        chk("stream first data", out_data[3*DW +: DW], 64'h3000);
      end
    end
    in_valid[3] = 1'b0;
    repeat (DLY + 5) tick();
    chk("stream pop count", pops3, 200);
    chk("stream drained", occ(3), 0);

    // Backpressure and full boundary on ch1.
    out_ready[1] = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      in_data[DW +: DW] = 64'h1000 + 64'(i);
      in_valid[1] = 1'b1;
      tick();
    end
    chk("bp in_ready low at full", in_ready[1], 0);
    chk("bp occ full", occ(1), DEP);
    in_data[DW +: DW] = 64'h1BAD;
    repeat (300 - DEP) tick();
    chk("bp still full", occ(1), DEP);
    chk("bp head aged", out_valid[1], 1);
    out_ready[1] = 1'b1;
    tick();
    chk("full pop without push", occ(1), DEP - 1);
    chk("full in_ready back", in_ready[1], 1);
    out_ready[1] = 1'b0;
    tick();
    chk("full push next cycle", occ(1), DEP);
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    chk("bp drain first data", out_data[DW +: DW], 64'h1001);
    run = 0;
    for (int i = 0; i < DEP; i++) begin
      if (out_valid[1]) run++;
      tick();
    end
    chk("bp drain consecutive", run, DEP);
    chk("bp drained", occ(1), 0);
    chk("bp out_valid low", out_valid[1], 0);

    // Reset with words in flight on every channel.
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = 64'h5000 + 64'(c * 16 + i);
      in_valid = '1;
      tick();
    end
    in_valid = '0;
    repeat (5) tick();
    chk("pre-reset occ ch5", occ(5), 10);
    rst = 1'b1;
    #1;
    chk("mid reset in_ready", 64'(in_ready), 64'd0);
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    chk("mid reset occupancy", 64'(occupancy), 64'd0);
    chk("mid reset out_data", 64'(|out_data), 64'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (DLY + 20) begin
      if (|out_valid) seen++;
      tick();
    end
    chk("no stale after reset", seen, 0);
    chk("occ after reset", 64'(occupancy), 64'd0);

    // link_enable low on ch2, ch4 unaffected.
    for (int i = 0; i < 5; i++) begin
      in_data[2*DW +: DW] = 64'h2000 + 64'(i);
      in_data[4*DW +: DW] = 64'h4000 + 64'(i);
      in_valid[2] = 1'b1;
      in_valid[4] = 1'b1;
      tick();
    end
    in_valid[2] = 1'b0;
    in_valid[4] = 1'b0;
    link_enable[2] = 1'b0;
    seen = 0;
    run = 0;
    repeat (100) begin
      if (out_valid[2]) seen++;
      if (out_valid[4]) run++;
      tick();
    end
    chk("ch2 silent while down", seen, 0);
    chk("ch2 in_ready masked", in_ready[2], 0);
    chk("ch2 words retained", occ(2), 5);
    chk("ch4 unaffected", run, 5);
    link_enable[2] = 1'b1;
    #1;
    chk("ch2 immediate on enable", out_valid[2], 1);
    chk("ch2 first data", out_data[2*DW +: DW], 64'h2000);
    run = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid[2]) run++;
      tick();
    end
    chk("ch2 back-to-back", run, 5);
    chk("ch2 drained", occ(2), 0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_delay_emulator.md
Name: link_delay_emulator

Overview:
- Synthesisable, parametrised model of the inter-FPGA link between the root hub and its leaves.
- Carries NUM_CHANNELS independent valid/ready streams of DATA_WIDTH bits.
- Each accepted word is released after exactly DELAY cycles, in order, with bounded in-flight depth and backpressure.
- Sits between root hub down/up ports and leaf parent ports in multi-FPGA benches and emulation builds; replaces a fixed-delay router model.

Parameters:
- NUM_CHANNELS, 8, number of independent streams.
- DATA_WIDTH, 64, payload width per channel.
- DELAY, 53, release latency in cycles; legal range 1..1023.
- DEPTH, 64, maximum words in flight per channel; power of two, >=2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_CHANNELS*DATA_WIDTH  packed input payloads; channel c in slice [c*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_CHANNELS  per-channel input valid.
- in_ready  out  NUM_CHANNELS  per-channel input ready.
- out_data  out  NUM_CHANNELS*DATA_WIDTH  packed output payloads.
- out_valid  out  NUM_CHANNELS  per-channel output valid.
- out_ready  in  NUM_CHANNELS  per-channel output ready.
- link_enable  in  NUM_CHANNELS  per-channel link up; low pauses the channel.
- occupancy  out  NUM_CHANNELS*(clog2(DEPTH)+1)  per-channel words in flight.

Behaviour:
- Channels are fully independent; all logic below is per channel.
- Reset values (asynchronous): FIFO empty, pointers 0, occupancy 0, in_ready 0, out_valid 0, out_data 0.
- Push: occurs at a clock edge when in_valid & in_ready.
  - Word is written at the write pointer together with a countdown loaded with DELAY.
- in_ready = link_enable & (occupancy < DEPTH), using registered occupancy.
  - At full, a pop in the same cycle does NOT enable a push; in_ready returns one cycle after the pop.
- Countdown: every stored entry's countdown decrements by 1 each edge and saturates at 0.
  - Counters keep running while link_enable is low or the output is stalled.
  - Countdown width is clog2(DELAY+1).
- out_valid = link_enable & (occupancy != 0) & (head countdown == 0).
  - out_data = head payload, registered from storage, stable while out_valid & !out_ready.
- Pop: occurs at an edge when out_valid & out_ready; the read pointer advances.
- Latency: a word pushed at edge E0 first shows out_valid in the cycle after edge E0+DELAY, i.e. exactly DELAY cycles later.
  - With out_ready held high, throughput is one word per cycle per channel after the initial DELAY.
- Ordering: strict FIFO; no drop, no duplication, no reordering.
- Stalled entries never lose eligibility; countdown saturation removes any wrap-around ambiguity.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged.
- Pointers: clog2(DEPTH) bits, wrap modulo DEPTH. Occupancy: clog2(DEPTH)+1 bits, range 0..DEPTH.
- link_enable deassertion:
  - Masks in_ready and out_valid combinationally.
  - Stored words are retained.
  - When re-enabled, words already aged past DELAY are presented immediately.
- Reset mid-operation flushes all in-flight words; no output appears after reset deasserts until new pushes age DELAY cycles.

Decomposition:
- Shared package:
  - clog2-derived widths (PTR_W, CNT_W, OCC_W).
  - The packed-vector slice macro.
  - Legal-range parameter checks (DELAY >= 1, DEPTH a power of two).
- Sub-module link_delay_channel: one FIFO with per-entry countdowns and handshake logic.
- The top generates NUM_CHANNELS instances and packs and unpacks the buses.

Test Plan:
- Single word: ch0 push 0xDEAD_BEEF_0000_0001 at edge 10, out_ready=1 -> out_valid rises after edge 63 (DELAY=53), data matches, occupancy 1->0.
- Streaming: ch3 pushes 200 incrementing words back-to-back, out_ready=1 -> 200 outputs on consecutive cycles starting 53 cycles after the first push, in order.
- Backpressure: ch1 out_ready=0 for 300 cycles while 64 words pushed -> in_ready drops after word 64, occupancy 64; release out_ready -> 64 words emitted on consecutive cycles, in order, none lost.
- Full boundary: occupancy 64 with pop and in_valid in the same cycle -> no push that cycle; push accepted next cycle, occupancy returns to 64.
- Reset mid-flight: 10 words in flight on all channels, assert reset 1 cycle -> all outputs 0 immediately, occupancy 0, no stale words emitted afterwards.
- Isolation and link_enable: ch2 link_enable low for 100 cycles with 5 words pushed before it -> ch2 silent, other channels unaffected; re-enable -> 5 words emitted back-to-back immediately.
